// File: rtl/imm_narrower_16_to_4.sv
// imm_narrower_16_to_4: splits a signed 16-bit value into the fewest 4-bit nibbles that sign-extend back to it
module imm_narrower_16_to_4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_nib,
    output logic        out_first,
    output logic        out_last,
    output logic        out_fits
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state, state_nx;
    logic [11:0] rest;
    logic [1:0] cnt, n_in;
    logic [15:0] aligned;
    logic f1, f2, f3, accept, take;
    assign in_ready = state == IDLE;
    assign out_valid = state == EMIT;
    assign accept = in_valid && in_ready;
    assign take = out_valid && out_ready;
    assign f1 = &in_data[15:3] | ~|in_data[15:3];
    assign f2 = &in_data[15:7] | ~|in_data[15:7];
    assign f3 = &in_data[15:11] | ~|in_data[15:11];
    assign n_in = f1 ? 2'd0 : f2 ? 2'd1 : f3 ? 2'd2 : 2'd3;
    assign aligned = in_data << {~n_in, 2'b00};
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = accept ? EMIT : IDLE;
        else
            state_nx = (take && out_last) ? IDLE : EMIT;
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst || (take && out_last)) begin
            out_nib   <= 4'h0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_fits  <= 1'b0;
            rest      <= 12'h0;
            cnt       <= 2'd0;
        end else if (accept) begin
            out_nib   <= aligned[15:12];
            rest      <= aligned[11:0];
            cnt       <= n_in;
            out_first <= 1'b1;
            out_last  <= n_in == 2'd0;
            out_fits  <= n_in == 2'd0;
        end else if (take) begin
            out_nib   <= rest[11:8];
            rest      <= {rest[7:0], 4'h0};
            cnt       <= cnt - 2'd1;
            out_first <= 1'b0;
            out_last  <= cnt == 2'd1;
        end
    end
endmodule
